csr_access_ctrl: RTL

//  Owns the machine CSR storage and the 64-bit cycle/instret counters, and serialises

---
 rtl/csr_access_ctrl_pkg.sv | 68 ++++++
 rtl/csr_access_ctrl_arb.sv | 24 ++
 rtl/csr_access_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/csr_access_ctrl_pkg.sv
// Package: csr_access_ctrl_pkg
// Shared definitions for the machine CSR access controller:
//   - CSR addresses of the implemented machine CSRs and counters
//   - CSR operation encodings (READ / WRITE / SET / CLEAR)
//   - controller FSM state encodings
//   - helpers for address decode and read-modify computation
package csr_access_ctrl_pkg;

  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    CSRC_IDLE = 2'b00,
    CSRC_RD   = 2'b01,
    CSRC_WB   = 2'b10
  } csrc_state_e;

  function automatic logic csr_is_legal(input logic [11:0] adr);
    case (adr)
      CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: csr_is_legal = 1'b1;
      default:                                          csr_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic csr_is_ro(input logic [11:0] adr);
    case (adr)
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: csr_is_ro = 1'b1;
      default:                                          csr_is_ro = 1'b0;
    endcase
  endfunction

  // New CSR value for a given op; READ leaves the value untouched.
  function automatic logic [31:0] csr_modify(input csr_op_e     op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: csr_modify = wdata;
      CSR_OP_SET:   csr_modify = old_val | wdata;
      CSR_OP_CLEAR: csr_modify = old_val & ~wdata;
      default:      csr_modify = old_val;
    endcase
  endfunction

  // SET/CLEAR with a zero mask is a pure read, so it never writes and never
  // trips the read-only check.
  function automatic logic csr_wants_write(input csr_op_e     op,
                                           input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE:              csr_wants_write = 1'b1;
      CSR_OP_SET, CSR_OP_CLEAR:  csr_wants_write = (wdata != 32'h0);
      default:                   csr_wants_write = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_access_ctrl_arb.sv
// Module: csr_rr_arb
// Two-way round-robin arbiter. When both requesters are valid the one that
// was not granted last wins; a lone requester is always granted.
// Ports:
//   valid_i      [1:0]  request valid per requester
//   last_grant_i        id of the requester granted most recently
//   grant_o      [1:0]  one-hot grant, zero when nothing is valid
module csr_rr_arb (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Module: csr_access_ctrl
// Owns machine CSR storage (mtvec, mscratch, mepc) and the 64-bit cycle and
// instret counters, and serialises read-modify-write accesses from two
// requesters (0 = core, 1 = debug) onto one shared response port.
//
// State table:
//   state     | meaning
//   CSRC_IDLE | waiting for a request; req_ready shows the arbiter grant
//   CSRC_RD   | old CSR value read, error decided, response registered
//   CSRC_WB   | new value written back; resp_valid high this cycle
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid[1:0]       request valid per requester
//   req_ready[1:0]       accept per requester (one-hot or zero)
//   req_op[3:0]          op per requester, requester i in [2i+1:2i]
//   req_adr[23:0]        CSR address per requester, requester i in [12i+11:12i]
//   req_wdata[63:0]      operand per requester, requester i in [32i+31:32i]
//   instret_inc          retire pulse
//   resp_valid           one-cycle response strobe
//   resp_id              requester owning the response
//   resp_rdata           CSR value before modification (0 on illegal address)
//   resp_err             illegal address or modifying write to a read-only CSR
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MSCR_RST  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_op,
  input  logic [23:0]       req_adr,
  input  logic [2*XLEN-1:0] req_wdata,
  input  logic              instret_inc,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  csrc_state_e     state_q;
  logic            last_grant_q;
  logic            cur_id_q;
  csr_op_e         op_q;
  logic [11:0]     adr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] old_q;
  logic            we_q;

  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [63:0]     cycle_q,   cycle_d;
  logic [63:0]     instret_q, instret_d;

  logic            resp_valid_q;
  logic            resp_id_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_err_q;

  logic [1:0]      grant;
  logic            grant_id;
  logic            hs;
  logic [XLEN-1:0] rd_val;
  logic            rd_err;
  logic            rd_mod;
  logic [XLEN-1:0] wb_data_d;

  csr_rr_arb u_arb (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Ready is gated by rst_n so it drops the moment reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == CSRC_IDLE)) begin
      req_ready = grant;
    end
    hs       = |(req_valid & req_ready);
    grant_id = grant[1];
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    case (adr_q)
      CSR_MTVEC:    rd_val = mtvec_q;
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_CYCLE:    rd_val = cycle_q[31:0];
      CSR_CYCLEH:   rd_val = cycle_q[63:32];
      CSR_INSTRET:  rd_val = instret_q[31:0];
      CSR_INSTRETH: rd_val = instret_q[63:32];
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    rd_mod    = csr_wants_write(op_q, wdata_q);
    rd_err    = !csr_is_legal(adr_q) || (csr_is_ro(adr_q) && rd_mod);
    wb_data_d = csr_modify(op_q, old_q, wdata_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CSRC_IDLE;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      op_q         <= CSR_OP_READ;
      adr_q        <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      we_q         <= 1'b0;
      mtvec_q      <= MTVEC_RST;
      mscratch_q   <= MSCR_RST;
      mepc_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        CSRC_IDLE: begin
          if (hs) begin
            cur_id_q     <= grant_id;
            op_q         <= csr_op_e'(grant_id ? req_op[3:2] : req_op[1:0]);
            adr_q        <= grant_id ? req_adr[23:12] : req_adr[11:0];
            wdata_q      <= grant_id ? req_wdata[2*XLEN-1:XLEN] : req_wdata[XLEN-1:0];
            last_grant_q <= grant_id;
            state_q      <= CSRC_RD;
          end
        end
        CSRC_RD: begin
          // The response is fully known here, so it is registered now and
          // appears in WB alongside the write-back.
          old_q        <= rd_val;
          we_q         <= rd_mod && !rd_err;
          resp_valid_q <= 1'b1;
          resp_id_q    <= cur_id_q;
          resp_rdata_q <= rd_val;
          resp_err_q   <= rd_err;
          state_q      <= CSRC_WB;
        end
        CSRC_WB: begin
          resp_valid_q <= 1'b0;
          if (we_q) begin
            case (adr_q)
              CSR_MTVEC:    mtvec_q    <= wb_data_d;
              CSR_MSCRATCH: mscratch_q <= wb_data_d;
              CSR_MEPC:     mepc_q     <= {wb_data_d[XLEN-1:2], 2'b00};
              default:      ;
            endcase
          end
          state_q <= CSRC_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= CSRC_IDLE;
        end
      endcase
    end
  end

  // Free-running counters, independent of the access FSM.
  always_comb begin
    cycle_d   = cycle_q + 64'd1;
    instret_d = instret_q + {63'd0, instret_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
